// File: rtl/gpu_pkg.sv
// Shared GPU definitions: DMA state encoding, VRAM geometry
// and the VRAM regions that CPU drivers refill by block transfer.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dma_state_t;

    localparam int VRAM_AW    = 12;
    localparam int VRAM_DEPTH = 1 << VRAM_AW;

    localparam logic [VRAM_AW-1:0] VRAM_ADDR_MAX = VRAM_AW'(VRAM_DEPTH - 1);

    localparam logic [VRAM_AW-1:0] FG_PAT_BASE  = 12'h000;
    localparam logic [VRAM_AW-1:0] BG_PAT_BASE  = 12'h400;
    localparam logic [VRAM_AW-1:0] OBJ_MEM_BASE = 12'h800;

endpackage

// File: rtl/vram_dma_buf.sv
// Two-entry byte FIFO between the source read return path
// and the VRAM write port of the block-transfer engine.
module vram_dma_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic [1:0] count
);

    logic [1:0][7:0] mem_q, mem_d;
    logic            wr_idx_q, wr_idx_d;
    logic            rd_idx_q, rd_idx_d;
    logic [1:0]      count_q, count_d;

    // Next FIFO contents from push/pop requests
    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (push) begin
            mem_d[wr_idx_q] = din;
            wr_idx_d        = ~wr_idx_q;
        end
        if (pop) begin
            rd_idx_d = ~rd_idx_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_idx_q];
    assign count = count_q;

endmodule

// File: rtl/vram_dma.sv
// Block-transfer engine: streams source bytes into VRAM,
// writing only while the video timing opens the write window.
module vram_dma
    import gpu_pkg::*;
#(
    parameter int VRAM_ADDR_WIDTH = 12,
    parameter int SRC_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SRC_ADDR_WIDTH-1:0]  src_base,
    input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
    input  logic [LEN_WIDTH-1:0]       len,
    output logic                       busy,
    output logic                       done,
    input  logic                       writable,
    output logic                       src_rd,
    output logic [SRC_ADDR_WIDTH-1:0]  src_addr,
    input  logic [7:0]                 src_data,
    output logic                       vram_we,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]                 vram_data
);

    localparam logic [SRC_ADDR_WIDTH-1:0]  SRC_ONE = SRC_ADDR_WIDTH'(1);
    localparam logic [VRAM_ADDR_WIDTH-1:0] DST_ONE = VRAM_ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]       LEN_ONE = LEN_WIDTH'(1);

    dma_state_t state_q, state_d;

    logic [SRC_ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [VRAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_WIDTH-1:0]       rd_left_q, rd_left_d;
    logic [LEN_WIDTH-1:0]       wr_left_q, wr_left_d;
    logic [1:0]                 credits_q, credits_d;
    logic                       rd_pend_q, rd_pend_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [1:0] buf_count;
    logic [7:0] buf_head;
    logic       run;
    logic       wr_now;
    logic       rd_go;
    logic       launch;

    assign run    = (state_q == RUN);
    assign launch = (state_q == IDLE) && start && (len != '0);

    // A buffered byte leaves whenever the window is open
    assign wr_now = writable && (buf_count != 2'd0);

    // Credits cover buffered bytes plus the read in flight, so a
    // read is only issued when its byte is sure to find a slot
    assign rd_go  = run && (rd_left_q != '0)
                  && ((credits_q - {1'b0, wr_now}) < 2'd2);
    assign src_rd = writable && rd_go;

    assign vram_we      = wr_now;
    assign vram_address = wr_ptr_q;
    assign vram_data    = buf_head;
    assign src_addr     = rd_ptr_q;
    assign busy         = busy_q;
    assign done         = done_q;

    vram_dma_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend_q),
        .din   (src_data),
        .pop   (wr_now),
        .head  (buf_head),
        .count (buf_count)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (wr_now && (wr_left_q == LEN_ONE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs, registered so busy/done come straight from flops
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Pointer, length and credit bookkeeping
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_left_d = rd_left_q;
        wr_left_d = wr_left_q;
        credits_d = credits_q;
        rd_pend_d = src_rd;
        if (launch) begin
            rd_ptr_d  = src_base;
            wr_ptr_d  = dst_base;
            rd_left_d = len;
            wr_left_d = len;
            credits_d = 2'd0;
        end else if (run) begin
            if (src_rd) begin
                rd_ptr_d  = rd_ptr_q + SRC_ONE;
                rd_left_d = rd_left_q - LEN_ONE;
            end
            if (wr_now) begin
                wr_ptr_d  = wr_ptr_q + DST_ONE;
                wr_left_d = wr_left_q - LEN_ONE;
            end
            credits_d = credits_q + {1'b0, src_rd} - {1'b0, wr_now};
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_left_q <= '0;
            wr_left_q <= '0;
            credits_q <= 2'd0;
            rd_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_left_q <= rd_left_d;
            wr_left_q <= wr_left_d;
            credits_q <= credits_d;
            rd_pend_q <= rd_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: latency, stalls, wrap,
// empty/ignored starts and mid-transfer reset.
module tb_vram_dma;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] src_base;
    logic [11:0] dst_base;
    logic [11:0] len;
    logic        busy;
    logic        done;
    logic        writable;
    logic        src_rd;
    logic [15:0] src_addr;
    logic [7:0]  src_data;
    logic        vram_we;
    logic [11:0] vram_address;
    logic [7:0]  vram_data;

    int errors = 0;
    int checks = 0;

    logic [11:0] w_addr [32];
    logic [7:0]  w_data [32];
    int          w_cyc  [32];
    logic [15:0] r_addr [32];
    int          r_cyc  [32];
    logic        busy_at[32];
    int nw, nr, ndone, done_cyc, nbusy, stall_strobes, maxcnt;
    logic rst_we, rst_busy;

    vram_dma dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .writable     (writable),
        .src_rd       (src_rd),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .vram_we      (vram_we),
        .vram_address (vram_address),
        .vram_data    (vram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory: byte at address a is 0xA0 + a[7:0], one cycle latency
    always @(posedge clk) begin
        if (src_rd) src_data <= 8'hA0 + src_addr[7:0];
    end

    // Drives one transfer for ncyc cycles (cycle 0 carries start) and records strobes
    task automatic run(input logic [15:0] s, input logic [11:0] d,
                       input logic [11:0] n, input logic [31:0] wmask,
                       input int ncyc, input int s2_cyc, input int rst_cyc);
        nw = 0; nr = 0; ndone = 0; done_cyc = -1; nbusy = 0;
        stall_strobes = 0; maxcnt = 0; rst_we = 1'b1; rst_busy = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            writable = wmask[c];
            start    = (c == 0) || (c == s2_cyc);
            rst      = (c == rst_cyc);
            if (c == s2_cyc) begin
                src_base = 16'h2000; dst_base = 12'h700; len = 12'd5;
            end else begin
                src_base = s; dst_base = d; len = n;
            end
            #4;
            busy_at[c] = busy;
            if (busy) nbusy++;
            if (vram_we && nw < 32) begin
                w_addr[nw] = vram_address; w_data[nw] = vram_data;
                w_cyc[nw] = c; nw++;
            end
            if (src_rd && nr < 32) begin
                r_addr[nr] = src_addr; r_cyc[nr] = c; nr++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!wmask[c] && (src_rd || vram_we)) stall_strobes++;
            if (int'(dut.buf_count) > maxcnt) maxcnt = int'(dut.buf_count);
            if (c == rst_cyc) begin
                rst_we = vram_we; rst_busy = busy;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; writable = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (src_rd !== 1'b0) begin errors++; $display("FAIL reset_src_rd: got %b want 0", src_rd); end
        checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_vram_we: got %b want 0", vram_we); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input string tag);
        run(16'h1000, 12'h200, 12'd4, 32'hFFFF_FFFF, 12, -1, -1);
        checks++; if (nw !== 4) begin errors++; $display("FAIL %s_nwrites: got %0d want 4", tag, nw); end
        checks++; if (nr !== 4) begin errors++; $display("FAIL %s_nreads: got %0d want 4", tag, nr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w_addr[i] !== 12'h200 + 12'(i)) begin errors++; $display("FAIL %s_waddr%0d: got %h want %h", tag, i, w_addr[i], 12'h200 + 12'(i)); end
            checks++; if (w_data[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL %s_wdata%0d: got %h want %h", tag, i, w_data[i], 8'hA0 + 8'(i)); end
            checks++; if (w_cyc[i] !== 3 + i) begin errors++; $display("FAIL %s_wcyc%0d: got %0d want %0d", tag, i, w_cyc[i], 3 + i); end
            checks++; if (r_addr[i] !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL %s_raddr%0d: got %h want %h", tag, i, r_addr[i], 16'h1000 + 16'(i)); end
            checks++; if (r_cyc[i] !== 1 + i) begin errors++; $display("FAIL %s_rcyc%0d: got %0d want %0d", tag, i, r_cyc[i], 1 + i); end
        end
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL %s_done_cyc: got %0d want 7", tag, done_cyc); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL %s_ndone: got %0d want 1", tag, ndone); end
        checks++; if (busy_at[1] !== 1'b1) begin errors++; $display("FAIL %s_busy_c1: got %b want 1", tag, busy_at[1]); end
        checks++; if (busy_at[7] !== 1'b0) begin errors++; $display("FAIL %s_busy_c7: got %b want 0", tag, busy_at[7]); end
    endtask

    task automatic test_stall();
        int exp_wc[4] = '{6, 8, 9, 10};
        run(16'h1000, 12'h200, 12'd4, 32'hFFFF_FFC3, 16, -1, -1);
        checks++; if (stall_strobes !== 0) begin errors++; $display("FAIL stall_strobes: got %0d want 0", stall_strobes); end
        checks++; if (nw !== 4) begin errors++; $display("FAIL stall_nwrites: got %0d want 4", nw); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w_data[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL stall_wdata%0d: got %h want %h", i, w_data[i], 8'hA0 + 8'(i)); end
            checks++; if (w_addr[i] !== 12'h200 + 12'(i)) begin errors++; $display("FAIL stall_waddr%0d: got %h want %h", i, w_addr[i], 12'h200 + 12'(i)); end
            checks++; if (w_cyc[i] !== exp_wc[i]) begin errors++; $display("FAIL stall_wcyc%0d: got %0d want %0d", i, w_cyc[i], exp_wc[i]); end
        end
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL stall_done_cyc: got %0d want 11", done_cyc); end
        checks++; if (maxcnt > 2) begin errors++; $display("FAIL stall_bufcount: got %0d want <=2", maxcnt); end
    endtask

    task automatic test_empty();
        run(16'h1000, 12'h200, 12'd0, 32'hFFFF_FFFF, 6, -1, -1);
        checks++; if (done_cyc !== 1) begin errors++; $display("FAIL empty_done_cyc: got %0d want 1", done_cyc); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL empty_ndone: got %0d want 1", ndone); end
        checks++; if (nbusy !== 0) begin errors++; $display("FAIL empty_busy: got %0d busy cycles want 0", nbusy); end
        checks++; if (nr !== 0) begin errors++; $display("FAIL empty_reads: got %0d want 0", nr); end
        checks++; if (nw !== 0) begin errors++; $display("FAIL empty_writes: got %0d want 0", nw); end
    endtask

    task automatic test_ignored_start();
        run(16'h1000, 12'h300, 12'd8, 32'hFFFF_FFFF, 16, 3, -1);
        checks++; if (nw !== 8) begin errors++; $display("FAIL ign_nwrites: got %0d want 8", nw); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (w_addr[i] !== 12'h300 + 12'(i)) begin errors++; $display("FAIL ign_waddr%0d: got %h want %h", i, w_addr[i], 12'h300 + 12'(i)); end
            checks++; if (w_data[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL ign_wdata%0d: got %h want %h", i, w_data[i], 8'hA0 + 8'(i)); end
        end
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL ign_done_cyc: got %0d want 11", done_cyc); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_ndone: got %0d want 1", ndone); end
    endtask

    task automatic test_wrap();
        logic [11:0] ea[3] = '{12'hFFE, 12'hFFF, 12'h000};
        logic [7:0]  ed[3] = '{8'h9F, 8'hA0, 8'hA1};
        logic [15:0] er[3] = '{16'hFFFF, 16'h0000, 16'h0001};
        run(16'hFFFF, 12'hFFE, 12'd3, 32'hFFFF_FFFF, 10, -1, -1);
        checks++; if (nw !== 3) begin errors++; $display("FAIL wrap_nwrites: got %0d want 3", nw); end
        checks++; if (nr !== 3) begin errors++; $display("FAIL wrap_nreads: got %0d want 3", nr); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (w_addr[i] !== ea[i]) begin errors++; $display("FAIL wrap_waddr%0d: got %h want %h", i, w_addr[i], ea[i]); end
            checks++; if (w_data[i] !== ed[i]) begin errors++; $display("FAIL wrap_wdata%0d: got %h want %h", i, w_data[i], ed[i]); end
            checks++; if (r_addr[i] !== er[i]) begin errors++; $display("FAIL wrap_raddr%0d: got %h want %h", i, r_addr[i], er[i]); end
        end
        checks++; if (done_cyc !== 6) begin errors++; $display("FAIL wrap_done_cyc: got %0d want 6", done_cyc); end
    endtask

    task automatic test_reset_mid();
        run(16'h1000, 12'h100, 12'd16, 32'hFFFF_FFFF, 24, -1, 5);
        checks++; if (rst_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b want 0", rst_we); end
        checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", rst_busy); end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_done: got %0d want 0", ndone); end
        checks++; if (nw !== 2) begin errors++; $display("FAIL rstmid_nwrites: got %0d want 2", nw); end
        test_basic("after_rst");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; writable = 1'b0;
        src_base = '0; dst_base = '0; len = '0; src_data = '0;
        test_reset();
        test_basic("basic");
        test_stall();
        test_empty();
        test_ignored_start();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
